// File: rtl/control_unit_staged.sv
// rtl/control_unit_staged.sv - RV32IM decode with registered ID/EX control word and MUL/DIV occupancy sequencing (optional: CU_ILLEGAL_DETECT_EN)
module control_unit_staged #(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic [4:0]  alu_signal,
    output logic        reg_file_write,
    output logic [2:0]  main_mem_write,
    output logic [3:0]  main_mem_read,
    output logic [3:0]  branch_control,
    output logic [3:0]  immediate_select,
    output logic        oparand_1_select,
    output logic        oparand_2_select,
    output logic [1:0]  reg_write_select,
    output logic        CTRL_VALID,
    output logic        HOLD_FETCH,
    output logic        MULDIV_DONE,
    output logic        ILLEGAL
);

    typedef struct packed {
        logic [4:0] alu;
        logic       rf_write;
        logic [2:0] mem_write;
        logic [3:0] mem_read;
        logic [3:0] branch;
        logic [3:0] imm_sel;
        logic       op1_sel;
        logic       op2_sel;
        logic [1:0] wb_sel;
    } ctrl_t;

    // BUSY means a MUL/DIV still has EX cycles left after the current one
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store, w_opimm, w_op;
    logic w_muldiv, w_illegal, w_unused;
    ctrl_t w_ctrl;
    state_t w_state;
    logic [CNT_W-1:0] w_cnt_init;

    ctrl_t r_ctrl;
    logic r_valid, r_illegal, r_muldiv, r_done;
    logic [CNT_W-1:0] r_count;

    assign w_opcode = INSTRUCTION[6:0];
    assign w_funct3 = INSTRUCTION[14:12];
    assign w_funct7 = INSTRUCTION[31:25];
    assign w_unused = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

    assign w_lui    = (w_opcode == 7'b0110111);
    assign w_auipc  = (w_opcode == 7'b0010111);
    assign w_jal    = (w_opcode == 7'b1101111);
    assign w_jalr   = (w_opcode == 7'b1100111);
    assign w_branch = (w_opcode == 7'b1100011);
    assign w_load   = (w_opcode == 7'b0000011);
    assign w_store  = (w_opcode == 7'b0100011);
    assign w_opimm  = (w_opcode == 7'b0010011);
    assign w_op     = (w_opcode == 7'b0110011);
    assign w_muldiv = w_op && (w_funct7 == 7'b0000001);

`ifdef CU_ILLEGAL_DETECT_EN
    logic w_known;
    assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store | w_opimm
                   | (w_op && (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000 || w_funct7 == 7'b0000001));
    assign w_illegal = ~w_known;
`else
    assign w_illegal = 1'b0;
`endif

    // funct3[2] separates the divide class from the multiply class
    assign w_cnt_init = w_funct3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

    assign w_state = (r_count != '0) ? ST_BUSY : ST_IDLE;

    // Combinational decode of the incoming instruction into the control bundle
    always_comb begin
        w_ctrl = '0;
        w_ctrl.alu[2:0] = (w_auipc | w_jal | w_load | w_store | w_branch) ? 3'b000 : w_funct3;
        w_ctrl.alu[4] = w_lui
                      | (w_opimm && w_funct3 == 3'b101 && w_funct7 == 7'b0100000)
                      | (w_op && w_funct3 == 3'b000 && w_funct7 == 7'b0100000)
                      | (w_op && w_funct3 == 3'b101 && w_funct7 == 7'b0100000);
        w_ctrl.alu[3] = w_muldiv | w_lui;
        w_ctrl.rf_write = w_lui | w_auipc | w_jal | w_jalr | w_load | w_opimm | w_op;
        w_ctrl.mem_write = w_store ? {1'b1, w_funct3[1:0]} : 3'b000;
        w_ctrl.mem_read = w_load ? {1'b1, w_funct3} : 4'b0000;
        if (w_branch)
            w_ctrl.branch = {1'b1, w_funct3};
        else if (w_jal | w_jalr)
            w_ctrl.branch = 4'b1010;
        // Immediate format: U=000 J=001 I=010 B=011 S=100 shift-I=101
        if (w_jal)
            w_ctrl.imm_sel[2:0] = 3'b001;
        else if (w_opimm && (w_funct3 == 3'b001 || w_funct3 == 3'b101))
            w_ctrl.imm_sel[2:0] = 3'b101;
        else if (w_jalr | w_load | w_opimm)
            w_ctrl.imm_sel[2:0] = 3'b010;
        else if (w_branch)
            w_ctrl.imm_sel[2:0] = 3'b011;
        else if (w_store)
            w_ctrl.imm_sel[2:0] = 3'b100;
        w_ctrl.imm_sel[3] = (w_load && (w_funct3 == 3'b100 || w_funct3 == 3'b101))
                          | (w_opimm && w_funct3 == 3'b011)
                          | (w_op && w_funct7 == 7'b0000000 && w_funct3 == 3'b011)
                          | (w_muldiv && (w_funct3 == 3'b010 || w_funct3 == 3'b011
                                       || w_funct3 == 3'b101 || w_funct3 == 3'b111));
        w_ctrl.op1_sel = w_auipc | w_jal | w_branch;
        w_ctrl.op2_sel = w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store | w_opimm;
        if (w_op | w_opimm | w_lui | w_auipc)
            w_ctrl.wb_sel = 2'b01;
        else if (w_load)
            w_ctrl.wb_sel = 2'b10;
        else if (w_jal | w_jalr)
            w_ctrl.wb_sel = 2'b11;
        if (w_illegal)
            w_ctrl = '0;
    end

    // ID/EX register and occupancy counter: reset > flush > hold > load
    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_muldiv  <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end else if (STALL || w_state == ST_BUSY) begin
            if (!STALL) begin
                r_count <= r_count - 1'b1;
                r_done  <= r_muldiv && (r_count == CNT_W'(1));
            end else begin
                r_done  <= 1'b0;
            end
        end else if (INSTR_VALID) begin
            r_ctrl    <= w_ctrl;
            r_valid   <= 1'b1;
            r_illegal <= w_illegal;
            r_muldiv  <= w_muldiv;
            r_count   <= w_muldiv ? w_cnt_init : '0;
            r_done    <= w_muldiv && (w_cnt_init == '0);
        end else begin
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_muldiv  <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
        end
    end

    assign alu_signal       = r_ctrl.alu;
    assign reg_file_write   = r_ctrl.rf_write;
    assign main_mem_write   = r_ctrl.mem_write;
    assign main_mem_read    = r_ctrl.mem_read;
    assign branch_control   = r_ctrl.branch;
    assign immediate_select = r_ctrl.imm_sel;
    assign oparand_1_select = r_ctrl.op1_sel;
    assign oparand_2_select = r_ctrl.op2_sel;
    assign reg_write_select = r_ctrl.wb_sel;
    assign CTRL_VALID       = r_valid;
    assign ILLEGAL          = r_illegal;
    assign MULDIV_DONE      = r_done;
    assign HOLD_FETCH       = (w_state == ST_BUSY);

endmodule

// File: tb/tb_control_unit_staged.sv
// tb/tb_control_unit_staged.sv - directed vector bench for control_unit_staged
module tb_control_unit_staged;

    logic        CLK = 1'b0;
    logic        RESET, INSTR_VALID, STALL, FLUSH;
    logic [31:0] INSTRUCTION;
    logic [4:0]  alu_signal;
    logic        reg_file_write;
    logic [2:0]  main_mem_write;
    logic [3:0]  main_mem_read, branch_control, immediate_select;
    logic        oparand_1_select, oparand_2_select;
    logic [1:0]  reg_write_select;
    logic        CTRL_VALID, HOLD_FETCH, MULDIV_DONE, ILLEGAL;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00A00093;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_DIV  = 32'h027342B3;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    control_unit_staged #(.MUL_CYCLES(1), .DIV_CYCLES(4), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
        .STALL(STALL), .FLUSH(FLUSH), .alu_signal(alu_signal), .reg_file_write(reg_file_write),
        .main_mem_write(main_mem_write), .main_mem_read(main_mem_read),
        .branch_control(branch_control), .immediate_select(immediate_select),
        .oparand_1_select(oparand_1_select), .oparand_2_select(oparand_2_select),
        .reg_write_select(reg_write_select), .CTRL_VALID(CTRL_VALID), .HOLD_FETCH(HOLD_FETCH),
        .MULDIV_DONE(MULDIV_DONE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic [28:0] exp;
    } vec_t;

    vec_t vt[12];

    function automatic logic [28:0] mk(input logic [4:0] alu, input logic rfw, input logic [2:0] mw,
                                       input logic [3:0] mr, input logic [3:0] bc, input logic [3:0] is,
                                       input logic op1, input logic op2, input logic [1:0] rws,
                                       input logic cv, input logic ill, input logic done, input logic hold);
        return {alu, rfw, mw, mr, bc, is, op1, op2, rws, cv, ill, done, hold};
    endfunction

    function automatic logic [28:0] obs();
        return {alu_signal, reg_file_write, main_mem_write, main_mem_read, branch_control,
                immediate_select, oparand_1_select, oparand_2_select, reg_write_select,
                CTRL_VALID, ILLEGAL, MULDIV_DONE, HOLD_FETCH};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        INSTRUCTION = ins;
        INSTR_VALID = v;
        STALL = st;
        FLUSH = fl;
    endtask

    logic [28:0] w_div_word;
    logic [28:0] w_nop;
    logic [28:0] w_addi;
    logic [28:0] w_sw;
    logic [28:0] w_bad;
    int hold_cycles;
    int done_seen;

    initial begin
        w_div_word = mk(5'b01100, 1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b01, 1, 0, 0, 0);
        w_nop      = '0;
        w_addi     = mk(5'b00000, 1, 3'b000, 4'b0000, 4'b0000, 4'b0010, 0, 1, 2'b01, 1, 0, 0, 0);
        w_sw       = mk(5'b00000, 0, 3'b110, 4'b0000, 4'b0000, 4'b0100, 0, 1, 2'b00, 1, 0, 0, 0);
`ifdef CU_ILLEGAL_DETECT_EN
        w_bad      = mk(5'b00000, 0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b00, 1, 1, 0, 0);
`else
        w_bad      = mk(5'b00000, 0, 3'b000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2'b00, 1, 0, 0, 0);
`endif
        vt[0]  = '{"addi",   I_ADDI,       1'b1, w_addi};
        vt[1]  = '{"sub",    I_SUB,        1'b1, mk(5'b10000, 1, 0, 0, 0, 4'b0000, 0, 0, 2'b01, 1, 0, 0, 0)};
        vt[2]  = '{"bubble", I_SUB,        1'b0, w_nop};
        vt[3]  = '{"sw",     I_SW,         1'b1, w_sw};
        vt[4]  = '{"lbu",    32'h00014083, 1'b1, mk(5'b00000, 1, 0, 4'b1100, 0, 4'b1010, 0, 1, 2'b10, 1, 0, 0, 0)};
        vt[5]  = '{"bne",    32'h00209463, 1'b1, mk(5'b00000, 0, 0, 0, 4'b1001, 4'b0011, 1, 1, 2'b00, 1, 0, 0, 0)};
        vt[6]  = '{"jal",    32'h000000EF, 1'b1, mk(5'b00000, 1, 0, 0, 4'b1010, 4'b0001, 1, 1, 2'b11, 1, 0, 0, 0)};
        vt[7]  = '{"lui",    32'h123402B7, 1'b1, mk(5'b11000, 1, 0, 0, 0, 4'b0000, 0, 1, 2'b01, 1, 0, 0, 0)};
        vt[8]  = '{"mulhu",  32'h023130B3, 1'b1, mk(5'b01011, 1, 0, 0, 0, 4'b1000, 0, 0, 2'b01, 1, 0, 1, 0)};
        vt[9]  = '{"srai",   32'h40315093, 1'b1, mk(5'b10101, 1, 0, 0, 0, 4'b0101, 0, 1, 2'b01, 1, 0, 0, 0)};
        vt[10] = '{"sltiu",  32'h00113093, 1'b1, mk(5'b00011, 1, 0, 0, 0, 4'b1010, 0, 1, 2'b01, 1, 0, 0, 0)};
        vt[11] = '{"jalr",   32'h000100E7, 1'b1, mk(5'b00000, 1, 0, 0, 4'b1010, 4'b0010, 0, 1, 2'b11, 1, 0, 0, 0)};

        // reset held two cycles with a live instruction at the input
        RESET = 1'b1;
        drive(I_ADDI, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_word", 32'(obs()), 32'(w_nop));
        RESET = 1'b0;

        // table: first entry is the ADDI loaded on the edge after reset release
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].instr, vt[i].valid, 1'b0, 1'b0);
            tick();
            chk(vt[i].name, 32'(obs()), 32'(vt[i].exp));
        end

        // DIV occupies EX for 4 cycles; next instruction waits behind it
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        tick();
        drive(I_ADDI, 1'b1, 1'b0, 1'b0);
        chk("div_c1", 32'(obs()), 32'(w_div_word | 29'b1));
        tick();
        chk("div_c2", 32'(obs()), 32'(w_div_word | 29'b1));
        tick();
        chk("div_c3", 32'(obs()), 32'(w_div_word | 29'b1));
        tick();
        chk("div_c4_done", 32'(obs()), 32'(w_div_word | 29'b10));
        tick();
        chk("div_next_addi", 32'(obs()), 32'(w_addi));

        // DIV flushed on its second EX cycle: NOP, no done pulse
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("flush_pre", 32'(obs()), 32'(w_div_word | 29'b1));
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush_word", 32'(obs()), 32'(w_nop));
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (MULDIV_DONE) done_seen++;
        end
        chk("flush_no_done", 32'(done_seen), 32'd0);

        // SW held through a 3-cycle stall
        drive(I_SW, 1'b1, 1'b0, 1'b0);
        tick();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sw_stall", 32'(obs()), 32'(w_sw));
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // stall during DIV freezes the counter: hold lasts 3 + 3 cycles
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        hold_cycles = HOLD_FETCH ? 1 : 0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (HOLD_FETCH) hold_cycles++;
            if (MULDIV_DONE) done_seen++;
        end
        STALL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (HOLD_FETCH) hold_cycles++;
            if (MULDIV_DONE) done_seen++;
        end
        chk("div_stall_hold", 32'(hold_cycles), 32'd6);
        chk("div_stall_done", 32'(done_seen), 32'd1);

        // reset mid-divide drops HOLD_FETCH immediately
        drive(I_DIV, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rst_mid_pre", 32'(HOLD_FETCH), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_mid_word", 32'(obs()), 32'(w_nop));

        // flush together with an accept drops the new instruction
        drive(I_ADDI, 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_accept", 32'(obs()), 32'(w_nop));

        // flush together with stall: flush wins
        drive(I_SW, 1'b1, 1'b0, 1'b0);
        tick();
        drive(I_SW, 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_stall", 32'(obs()), 32'(w_nop));

        // unsupported opcode
        drive(I_BAD, 1'b1, 1'b0, 1'b0);
        tick();
        chk("illegal_op", 32'(obs()), 32'(w_bad));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
